// File: rtl/router_in_vc_scheduler.sv
// Round-robin flit scheduler feeding one router input port from VC_NUM sources.
// Keeps per-VC packet framing and quarantines a VC after a port error.
module router_in_vc_scheduler #(
  parameter int VC_NUM = 2,
  parameter int FLIT_W = 64,
  localparam int VW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [VC_NUM-1:0]        req_valid_i,
  input  logic [VC_NUM*FLIT_W-1:0] req_flit_i,
  input  logic [VC_NUM-1:0]        req_head_i,
  input  logic [VC_NUM-1:0]        req_tail_i,
  output logic [VC_NUM-1:0]        req_ready_o,
  input  logic [VC_NUM-1:0]        on_off_i,
  input  logic [VC_NUM-1:0]        vc_allocatable_i,
  input  logic [VC_NUM-1:0]        error_i,
  input  logic [VC_NUM-1:0]        err_clr_i,
  output logic [FLIT_W-1:0]        data_o,
  output logic [VW-1:0]            vc_o,
  output logic                     valid_flit_o,
  output logic [VC_NUM-1:0]        open_o,
  output logic [VC_NUM-1:0]        err_o
);

  logic [VC_NUM-1:0] elig;
  logic [VC_NUM-1:0] gnt;
  logic [VC_NUM-1:0] open_q, open_d;
  logic [VC_NUM-1:0] err_q, err_d;
  logic [VW-1:0]     ptr_q, ptr_d;
  logic [VW-1:0]     gidx, idx;
  logic              found;
  logic [FLIT_W-1:0] flit_sel;
  logic [FLIT_W-1:0] data_q;
  logic [VW-1:0]     vc_q;
  logic              valid_q;

  // A head needs a closed, allocatable VC; a body/tail needs an open one.
  always_comb begin
    elig = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      elig[v] = req_valid_i[v] & on_off_i[v] & ~err_q[v] &
                (req_head_i[v] ? (~open_q[v] & vc_allocatable_i[v])
                               : open_q[v]);
    end
  end

  always_comb begin
    found = 1'b0;
    gidx  = '0;
    idx   = '0;
    gnt   = '0;
    for (int i = 0; i < VC_NUM; i++) begin
      if (int'(ptr_q) + i >= VC_NUM)
        idx = VW'(int'(ptr_q) + i - VC_NUM);
      else
        idx = VW'(int'(ptr_q) + i);
      if (!found && elig[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end
    if (found && !rst)
      gnt[gidx] = 1'b1;
  end

  always_comb begin
    flit_sel = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      if (gidx == VW'(v))
        flit_sel = req_flit_i[v*FLIT_W +: FLIT_W];
    end
  end

  assign ptr_d = (gidx == VW'(VC_NUM - 1)) ? '0 : gidx + VW'(1);

  // A port error overrides any framing update from a same-cycle grant.
  always_comb begin
    open_d = open_q;
    err_d  = err_q;
    for (int v = 0; v < VC_NUM; v++) begin
      if (gnt[v]) begin
        if (req_head_i[v] & ~req_tail_i[v])
          open_d[v] = 1'b1;
        else if (req_tail_i[v])
          open_d[v] = 1'b0;
      end
      if (error_i[v]) begin
        open_d[v] = 1'b0;
        err_d[v]  = 1'b1;
      end else if (err_clr_i[v]) begin
        err_d[v]  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      open_q  <= '0;
      err_q   <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
      vc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      open_q  <= open_d;
      err_q   <= err_d;
      valid_q <= found;
      if (found) begin
        data_q <= flit_sel;
        vc_q   <= gidx;
        ptr_q  <= ptr_d;
      end
    end
  end

  assign req_ready_o  = gnt;
  assign data_o       = data_q;
  assign vc_o         = vc_q;
  assign valid_flit_o = valid_q;
  assign open_o       = open_q;
  assign err_o        = err_q;

endmodule
